// File: rtl/cache_way_array.sv
// cache_way_array: multi-way, byte-maskable storage array with a shared index port.
// Reads are registered with write-first bypass, and a clear sequencer zeroes every
// set after reset or on a flush request.
// Optional parity protection is enabled by defining CACHE_ARRAY_PARITY_EN.
module cache_way_array #(
  parameter int s_index  = 3,
  parameter int width    = 256,
  parameter int num_ways = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          read,
  input  logic [num_ways-1:0]           load,
  input  logic [s_index-1:0]            index,
  input  logic [width-1:0]              datain,
  input  logic [width/8-1:0]            wmask,
  input  logic                          flush,
`ifdef CACHE_ARRAY_PARITY_EN
  input  logic                          par_inject,
  output logic [num_ways-1:0]           parity_err,
`endif
  output logic                          busy,
  output logic [num_ways*width-1:0]     dataout
);

  localparam int num_sets  = 2 ** s_index;
  localparam int num_bytes = width / 8;
  localparam logic [s_index-1:0] last_set = s_index'(num_sets - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [s_index-1:0]          cnt_q, cnt_d;
  logic [num_ways*width-1:0]   dataout_q, dataout_d;
  logic                        rd_accept;
  logic [width-1:0]            rd_word;

  // Storage is deliberately not reset; the clear sweep zeroes it set by set.
  logic [width-1:0]            mem [num_ways][num_sets];

`ifdef CACHE_ARRAY_PARITY_EN
  logic [num_bytes-1:0]        par_mem [num_ways][num_sets];
  logic [num_bytes-1:0]        rd_par;
  logic [num_ways-1:0]         parity_err_q, parity_err_d;
`endif

  // Sweep sequencer: count through every set in CLEAR, sit in IDLE until a flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == last_set) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign rd_accept = (state_q == ST_IDLE) && read;

  // Read path: merge any same-cycle load into the stored word (write-first).
  always_comb begin
    dataout_d = dataout_q;
    rd_word   = '0;
`ifdef CACHE_ARRAY_PARITY_EN
    parity_err_d = parity_err_q;
    rd_par       = '0;
`endif
    for (int w = 0; w < num_ways; w++) begin
      rd_word = mem[w][index];
`ifdef CACHE_ARRAY_PARITY_EN
      rd_par = par_mem[w][index];
`endif
      for (int i = 0; i < num_bytes; i++) begin
        if (load[w] && wmask[i]) begin
          rd_word[8*i +: 8] = datain[8*i +: 8];
`ifdef CACHE_ARRAY_PARITY_EN
          rd_par[i] = (^datain[8*i +: 8]) ^ par_inject;
`endif
        end
      end
      if (rd_accept) begin
        dataout_d[w*width +: width] = rd_word;
`ifdef CACHE_ARRAY_PARITY_EN
        parity_err_d[w] = 1'b0;
        for (int i = 0; i < num_bytes; i++) begin
          if ((^rd_word[8*i +: 8]) != rd_par[i]) begin
            parity_err_d[w] = 1'b1;
          end
        end
`endif
      end
    end
  end

  // Control and output registers, asynchronously returned to the clear state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      dataout_q <= '0;
`ifdef CACHE_ARRAY_PARITY_EN
      parity_err_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dataout_q <= dataout_d;
`ifdef CACHE_ARRAY_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Array writes: the sweep zeroes one set per cycle, otherwise byte-masked loads.
  always_ff @(posedge clk) begin
    for (int w = 0; w < num_ways; w++) begin
      if (busy) begin
        mem[w][cnt_q] <= '0;
`ifdef CACHE_ARRAY_PARITY_EN
        par_mem[w][cnt_q] <= '0;
`endif
      end else if (load[w]) begin
        for (int i = 0; i < num_bytes; i++) begin
          if (wmask[i]) begin
            mem[w][index][8*i +: 8] <= datain[8*i +: 8];
`ifdef CACHE_ARRAY_PARITY_EN
            par_mem[w][index][i] <= (^datain[8*i +: 8]) ^ par_inject;
`endif
          end
        end
      end
    end
  end

  assign dataout = dataout_q;
`ifdef CACHE_ARRAY_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_cache_way_array.sv
// tb_cache_way_array: directed plus random stimulus for cache_way_array, compared
// against an abstract array model (whole-array clear, byte-merge reads).
// Parity checks are compiled in when CACHE_ARRAY_PARITY_EN is defined.
module tb_cache_way_array;
  localparam int SI = 3;
  localparam int W  = 256;
  localparam int NW = 2;
  localparam int NS = 2 ** SI;
  localparam int NB = W / 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               read = 1'b0;
  logic [NW-1:0]      load = '0;
  logic [SI-1:0]      index = '0;
  logic [W-1:0]       datain = '0;
  logic [NB-1:0]      wmask = '0;
  logic               flush = 1'b0;
  logic               busy;
  logic [NW*W-1:0]    dataout;
`ifdef CACHE_ARRAY_PARITY_EN
  logic               par_inject = 1'b0;
  logic [NW-1:0]      parity_err;
`endif

  cache_way_array #(.s_index(SI), .width(W), .num_ways(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .read      (read),
    .load      (load),
    .index     (index),
    .datain    (datain),
    .wmask     (wmask),
    .flush     (flush),
`ifdef CACHE_ARRAY_PARITY_EN
    .par_inject(par_inject),
    .parity_err(parity_err),
`endif
    .busy      (busy),
    .dataout   (dataout)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0]  mm [NW][NS];
  bit            corrupt [NW][NS][NB];
  logic [W-1:0]  exp_way [NW];
  logic [NW-1:0] exp_perr;
  int            clear_left;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      exp_way[w] = '0;
      for (int s = 0; s < NS; s++) begin
        mm[w][s] = '0;
        for (int i = 0; i < NB; i++) corrupt[w][s][i] = 1'b0;
      end
    end
    exp_perr   = '0;
    clear_left = NS;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_busy"}, W'(busy), W'(clear_left > 0));
    for (int w = 0; w < NW; w++)
      chk($sformatf("%s_dout_w%0d", tag, w), dataout[w*W +: W], exp_way[w]);
`ifdef CACHE_ARRAY_PARITY_EN
    chk({tag, "_perr"}, W'(parity_err), W'(exp_perr));
`endif
  endtask

  // One clock cycle: drive at the falling edge, update the model, check after the rising edge.
  task automatic step(input string tag, input logic r, input logic [NW-1:0] ld,
                      input logic [SI-1:0] idx, input logic [W-1:0] din,
                      input logic [NB-1:0] wm, input logic fl, input logic inj);
    logic [W-1:0] merged;
    @(negedge clk);
    rst = 1'b0; read = r; load = ld; index = idx; datain = din; wmask = wm; flush = fl;
`ifdef CACHE_ARRAY_PARITY_EN
    par_inject = inj;
`endif
    if (clear_left > 0) begin
      clear_left--;
    end else begin
      if (r) begin
        for (int w = 0; w < NW; w++) begin
          merged = mm[w][idx];
          exp_perr[w] = 1'b0;
          for (int i = 0; i < NB; i++) begin
            if (ld[w] && wm[i]) begin
              merged[8*i +: 8] = din[8*i +: 8];
              if (inj) exp_perr[w] = 1'b1;
            end else if (corrupt[w][idx][i]) begin
              exp_perr[w] = 1'b1;
            end
          end
          exp_way[w] = merged;
        end
      end
      for (int w = 0; w < NW; w++)
        if (ld[w])
          for (int i = 0; i < NB; i++)
            if (wm[i]) begin
              mm[w][idx][8*i +: 8] = din[8*i +: 8];
              corrupt[w][idx][i] = inj;
            end
      if (fl) begin
        for (int w = 0; w < NW; w++)
          for (int s = 0; s < NS; s++) begin
            mm[w][s] = '0;
            for (int i = 0; i < NB; i++) corrupt[w][s][i] = 1'b0;
          end
        clear_left = NS;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [SI-1:0] idx);
    step(tag, 1'b1, '0, idx, '0, '0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted immediately, held across one rising edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs({tag, "_async"});
    @(posedge clk);
    #1;
    check_outputs({tag, "_held"});
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] ones;
    int n;
    ones = '1;

    // Reset release: busy for exactly NS cycles
    do_reset("rst0");
    n = 0;
    for (int c = 0; c < NS + 4; c++) begin
      idle("sweep");
      if (busy === 1'b1) n++;
    end
    chk("busy_len_reset", W'(n), W'(NS - 1));
    for (int s = 0; s < NS; s++) rd("rd_zero", SI'(s));

    // Single way load, full mask
    v = {32{8'hA5}};
    step("ld_a5", 1'b0, 2'b01, 3'd5, v, '1, 1'b0, 1'b0);
    rd("rd_a5", 3'd5);
    chk("a5_way0", dataout[0 +: W], v);
    chk("a5_way1", dataout[W +: W], '0);

    // Partial byte mask retains other bytes
    step("ld_ff", 1'b0, 2'b10, 3'd2, ones, '1, 1'b0, 1'b0);
    step("ld_mask", 1'b0, 2'b10, 3'd2, '0, 32'h0000_000F, 1'b0, 1'b0);
    rd("rd_mask", 3'd2);
    v = {{28{8'hFF}}, 32'h0};
    chk("mask_way1", dataout[W +: W], v);

    // Same-cycle read and load: write-first on loaded way only
    v = rand_word();
    step("ld_w0_3", 1'b0, 2'b01, 3'd3, v, '1, 1'b0, 1'b0);
    step("byp", 1'b1, 2'b10, 3'd3, 256'h1234, '1, 1'b0, 1'b0);
    chk("byp_way1", dataout[W +: W], 256'h1234);
    chk("byp_way0", dataout[0 +: W], v);

    // Fill all sets, flush with a concurrent load + read at index 7
    for (int s = 0; s < NS; s++)
      step("fill", 1'b0, 2'b11, SI'(s), rand_word(), '1, 1'b0, 1'b0);
    v = rand_word();
    step("flush_ld", 1'b1, 2'b01, 3'd7, v, '1, 1'b1, 1'b0);
    chk("flush_ld_way0", dataout[0 +: W], v);
    n = (busy === 1'b1) ? 1 : 0;
    for (int c = 0; c < NS + 3; c++) begin
      step("clr_rd", 1'b1, 2'b11, SI'($urandom_range(NS - 1)), rand_word(), '1,
           (c == 2) ? 1'b1 : 1'b0, 1'b0);
      if (busy === 1'b1) n++;
    end
    chk("busy_len_flush", W'(n), W'(NS));
    for (int s = 0; s < NS; s++) rd("rd_flushed", SI'(s));

`ifdef CACHE_ARRAY_PARITY_EN
    // Parity fault injection and recovery
    step("par_inj", 1'b0, 2'b01, 3'd1, rand_word(), '1, 1'b0, 1'b1);
    rd("par_rd1", 3'd1);
    chk("par_err_set", W'(parity_err), W'(2'b01));
    step("par_fix", 1'b0, 2'b01, 3'd1, rand_word(), '1, 1'b0, 1'b0);
    rd("par_rd2", 3'd1);
    chk("par_err_clr", W'(parity_err), W'(2'b00));
`endif

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      logic [NB-1:0] wm;
      case ($urandom_range(3))
        0: wm = '0;
        1: wm = '1;
        default: wm = $urandom;
      endcase
      step("rnd", 1'($urandom_range(1)), NW'($urandom), SI'($urandom), rand_word(), wm,
           ($urandom_range(49) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(7) == 0) ? 1'b1 : 1'b0);
    end
    for (int c = 0; c < NS; c++) idle("drain");

    // Reset mid-CLEAR restarts the sweep from set 0
    step("flush2", 1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    idle("mid_clr");
    idle("mid_clr");
    do_reset("rst_clr");
    for (int c = 0; c < NS + 2; c++) idle("sweep2");

    // Reset mid-IDLE with non-zero dataout
    v = rand_word();
    step("ld_pre", 1'b1, 2'b11, 3'd4, v, '1, 1'b0, 1'b0);
    chk("pre_rst_way1", dataout[W +: W], v);
    do_reset("rst_idle");
    for (int c = 0; c < NS + 2; c++) idle("sweep3");
    for (int s = 0; s < NS; s++) rd("rd_end", SI'(s));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
